// File: rtl/write_buffer.sv
// Circular write buffer for evicted dirty lines. Lines drain to memory in FIFO order, and pushes are dropped (sticky wb_overflow) while full.
// Push to mem_wr_req takes 2 cycles minimum, and each line then waits for mem_wr_ack. Optional WB_FORWARD_EN adds a lookup port with a 1-cycle registered result.
module write_buffer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int CACHELINE_WIDTH = 128,
    parameter int OFFSET_WIDTH    = 4,
    parameter int DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_push_en,
    input  logic [ADDR_WIDTH-1:0]      wb_push_addr,
    input  logic [CACHELINE_WIDTH-1:0] wb_push_data,
    output logic                       wb_full,
    output logic                       wb_empty,
    output logic                       wb_overflow,
    output logic                       mem_wr_req,
    output logic [ADDR_WIDTH-1:0]      mem_wr_addr,
    output logic [CACHELINE_WIDTH-1:0] mem_wr_data,
    input  logic                       mem_wr_ack
`ifdef WB_FORWARD_EN
    ,
    input  logic                       lookup_en,
    input  logic [ADDR_WIDTH-1:0]      lookup_addr,
    output logic                       lookup_hit,
    output logic [CACHELINE_WIDTH-1:0] lookup_data
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                     state_q, state_d;
    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]      addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0]      addr_d [DEPTH];
    logic [CACHELINE_WIDTH-1:0] data_q [DEPTH];
    logic [CACHELINE_WIDTH-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]             count_q, count_d;
    logic                       full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;
    logic                       req_q, req_d;
    logic [ADDR_WIDTH-1:0]      wr_addr_q, wr_addr_d;
    logic [CACHELINE_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                       push_ok, pop;
    logic                       unused_push_offset;

    assign unused_push_offset = ^wb_push_addr[OFFSET_WIDTH-1:0];

    always_comb begin
        push_ok    = wb_push_en && !full_q;
        pop        = (state_q == REQ) && mem_wr_ack;
        valid_d    = valid_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        state_d    = state_q;
        req_d      = req_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        overflow_d = overflow_q || (wb_push_en && full_q);

        // wr_ptr == rd_ptr only when empty or full, so push and pop never touch the same slot
        if (push_ok) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = {wb_push_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
            data_d[wr_ptr_q]  = wb_push_data;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    req_d     = 1'b1;
                    wr_addr_d = addr_q[rd_ptr_q];
                    wr_data_d = data_q[rd_ptr_q];
                    state_d   = REQ;
                end
            end
            default: begin
                if (mem_wr_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            req_q      <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            req_q      <= req_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Payload storage is qualified by valid_q, so it needs no reset
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign wb_full     = full_q;
    assign wb_empty    = empty_q;
    assign wb_overflow = overflow_q;
    assign mem_wr_req  = req_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;

`ifdef WB_FORWARD_EN
    logic                       hit_q, hit_d;
    logic [CACHELINE_WIDTH-1:0] ldata_q, ldata_d;
    logic [PTR_W-1:0]           idx;
    logic                       unused_lookup_offset;

    assign unused_lookup_offset = ^lookup_addr[OFFSET_WIDTH-1:0];

    // Walk oldest to youngest so the last match (nearest wr_ptr-1) wins
    always_comb begin
        hit_d   = 1'b0;
        ldata_d = '0;
        idx     = '0;
        if (lookup_en) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd_ptr_q + PTR_W'(k);
                if (valid_q[idx] && !(pop && idx == rd_ptr_q) &&
                    addr_q[idx][ADDR_WIDTH-1:OFFSET_WIDTH] == lookup_addr[ADDR_WIDTH-1:OFFSET_WIDTH]) begin
                    hit_d   = 1'b1;
                    ldata_d = data_q[idx];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q   <= 1'b0;
            ldata_q <= '0;
        end else begin
            hit_q   <= hit_d;
            ldata_q <= ldata_d;
        end
    end

    assign lookup_hit  = hit_q;
    assign lookup_data = ldata_q;
`endif
endmodule

// File: tb/tb_write_buffer.sv
// Randomised bench for write_buffer: a queue-based reference model is compared every cycle, and directed scenarios carry literal expectations.
module tb_write_buffer;
    localparam int AW = 32;
    localparam int CW = 128;
    localparam int OW = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wb_push_en = 1'b0;
    logic [AW-1:0] wb_push_addr = '0;
    logic [CW-1:0] wb_push_data = '0;
    logic          wb_full, wb_empty, wb_overflow;
    logic          mem_wr_req;
    logic [AW-1:0] mem_wr_addr;
    logic [CW-1:0] mem_wr_data;
    logic          mem_wr_ack = 1'b0;
`ifdef WB_FORWARD_EN
    logic          lookup_en = 1'b0;
    logic [AW-1:0] lookup_addr = '0;
    logic          lookup_hit;
    logic [CW-1:0] lookup_data;
`endif

    always #5 clk = ~clk;

    write_buffer #(.ADDR_WIDTH(AW), .CACHELINE_WIDTH(CW), .OFFSET_WIDTH(OW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_push_en(wb_push_en), .wb_push_addr(wb_push_addr), .wb_push_data(wb_push_data),
        .wb_full(wb_full), .wb_empty(wb_empty), .wb_overflow(wb_overflow),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ack(mem_wr_ack)
`ifdef WB_FORWARD_EN
        , .lookup_en(lookup_en), .lookup_addr(lookup_addr),
        .lookup_hit(lookup_hit), .lookup_data(lookup_data)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: pending lines as a queue, plus the line currently offered to memory
    typedef struct packed {
        logic [AW-1:0] a;
        logic [CW-1:0] d;
    } ent_t;

    ent_t          q[$];
    bit            m_req = 1'b0;
    ent_t          m_cur = '0;
    bit            m_ovf = 1'b0;
    bit            m_hit = 1'b0;
    logic [CW-1:0] m_ldata = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            m_req = 1'b0; m_cur = '0; m_ovf = 1'b0; m_hit = 1'b0; m_ldata = '0;
        end else begin
            int n;
            n = q.size();
            if (m_req && mem_wr_ack) begin
                void'(q.pop_front());
                m_req = 1'b0;
            end else if (!m_req && n != 0) begin
                m_req = 1'b1;
                m_cur = q[0];
            end
            m_hit = 1'b0;
            m_ldata = '0;
`ifdef WB_FORWARD_EN
            if (lookup_en)
                foreach (q[i])
                    if (q[i].a[AW-1:OW] == lookup_addr[AW-1:OW]) begin
                        m_hit = 1'b1;
                        m_ldata = q[i].d;
                    end
`endif
            if (wb_push_en) begin
                if (n == D) m_ovf = 1'b1;
                else q.push_back({wb_push_addr & ~32'hF, wb_push_data});
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("m_full",  CW'(wb_full),     CW'(q.size() == D));
        check("m_empty", CW'(wb_empty),    CW'(q.size() == 0));
        check("m_ovf",   CW'(wb_overflow), CW'(m_ovf));
        check("m_req",   CW'(mem_wr_req),  CW'(m_req));
        if (m_req) begin
            check("m_addr", CW'(mem_wr_addr), CW'(m_cur.a));
            check("m_data", mem_wr_data, m_cur.d);
        end
`ifdef WB_FORWARD_EN
        check("m_hit",   CW'(lookup_hit), CW'(m_hit));
        check("m_ldata", lookup_data, m_ldata);
`endif
    end

    task automatic push(input logic [AW-1:0] a, input logic [CW-1:0] d);
        wb_push_en = 1'b1; wb_push_addr = a; wb_push_data = d;
        @(negedge clk);
        wb_push_en = 1'b0;
    endtask

    task automatic ack_one();
        mem_wr_ack = 1'b1;
        @(negedge clk);
        mem_wr_ack = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!mem_wr_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!mem_wr_req) begin
            tests++;
            fails++;
            $display("FAIL %s: mem_wr_req still 0 after 20 cycles, expected 1", name);
        end
    endtask

    logic [AW-1:0] exp_a;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_empty", CW'(wb_empty), CW'(1'b1));
        check("rst_full",  CW'(wb_full),  CW'(1'b0));
        check("rst_req",   CW'(mem_wr_req), CW'(1'b0));
        check("rst_addr",  CW'(mem_wr_addr), CW'(32'h0));

        // Single line: request appears two edges after the push
        push(32'h0000_1234, {32{4'hA}});
        check("t1_empty_after_push", CW'(wb_empty), CW'(1'b0));
        check("t1_req_early", CW'(mem_wr_req), CW'(1'b0));
        @(negedge clk);
        check("t1_req", CW'(mem_wr_req), CW'(1'b1));
        check("t1_addr", CW'(mem_wr_addr), CW'(32'h0000_1230));
        check("t1_data", mem_wr_data, {32{4'hA}});
        ack_one();
        check("t1_req_drop", CW'(mem_wr_req), CW'(1'b0));
        check("t1_empty", CW'(wb_empty), CW'(1'b1));

        // Five back-to-back pushes into a 4-deep buffer
        for (int i = 0; i < 5; i++) begin
            push(32'h1000 * (i + 1) + i, {4{32'(i + 1)}});
            if (i == 3) check("t2_full", CW'(wb_full), CW'(1'b1));
        end
        check("t2_ovf", CW'(wb_overflow), CW'(1'b1));
        check("t2_full_kept", CW'(wb_full), CW'(1'b1));
        for (int c = 0; c < 10; c++) begin
            check("t3_req_hold", CW'(mem_wr_req), CW'(1'b1));
            check("t3_addr_hold", CW'(mem_wr_addr), CW'(32'h1000));
            check("t3_data_hold", mem_wr_data, {4{32'd1}});
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            wait_req("t2_drain_wait");
            exp_a = 32'h1000 * (i + 1);
            check("t2_drain_addr", CW'(mem_wr_addr), CW'(exp_a));
            check("t2_drain_data", mem_wr_data, {4{32'(i + 1)}});
            ack_one();
        end
        @(negedge clk);
        check("t2_empty", CW'(wb_empty), CW'(1'b1));

        // Full buffer, push and ack on the same edge: push refused, three lines remain
        for (int i = 0; i < 4; i++) push(32'h2000 + 32'h10 * i, {4{32'h2000 + 32'(i)}});
        wait_req("t4_wait");
        wb_push_en = 1'b1; wb_push_addr = 32'h2040; wb_push_data = '1;
        mem_wr_ack = 1'b1;
        @(negedge clk);
        wb_push_en = 1'b0; mem_wr_ack = 1'b0;
        check("t4_full", CW'(wb_full), CW'(1'b0));
        check("t4_empty", CW'(wb_empty), CW'(1'b0));
        for (int i = 1; i < 4; i++) begin
            wait_req("t4_drain_wait");
            exp_a = 32'h2000 + 32'h10 * i;
            check("t4_drain_addr", CW'(mem_wr_addr), CW'(exp_a));
            ack_one();
        end
        @(negedge clk);
        check("t4_empty_end", CW'(wb_empty), CW'(1'b1));

`ifdef WB_FORWARD_EN
        push(32'h100, {4{32'hD1D1_D1D1}});
        push(32'h100, {4{32'hD2D2_D2D2}});
        lookup_en = 1'b1; lookup_addr = 32'h10C;
        @(negedge clk);
        check("t5_hit", CW'(lookup_hit), CW'(1'b1));
        check("t5_data", lookup_data, {4{32'hD2D2_D2D2}});
        lookup_addr = 32'h200;
        @(negedge clk);
        lookup_en = 1'b0;
        check("t5_miss", CW'(lookup_hit), CW'(1'b0));
        check("t5_miss_data", lookup_data, CW'(0));
        for (int i = 0; i < 2; i++) begin
            wait_req("t5_drain_wait");
            ack_one();
        end
`endif

        // Asynchronous reset while a request is outstanding
        push(32'h3456, {4{32'h3333_3333}});
        wait_req("t6_wait");
        #2 rst_n = 1'b0;
        #1;
        check("t6_req", CW'(mem_wr_req), CW'(1'b0));
        check("t6_addr", CW'(mem_wr_addr), CW'(32'h0));
        check("t6_data", mem_wr_data, CW'(0));
        check("t6_empty", CW'(wb_empty), CW'(1'b1));
        check("t6_ovf", CW'(wb_overflow), CW'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        push(32'h5678, {4{32'h5555_5555}});
        wait_req("t6_after_wait");
        check("t6_after_addr", CW'(mem_wr_addr), CW'(32'h5670));
        ack_one();

        // Randomised traffic with acks also arriving while idle
        for (int c = 0; c < 3000; c++) begin
            wb_push_en   = ($urandom_range(0, 9) < 4);
            wb_push_addr = 32'h4000 + ($urandom_range(0, 5) << 4) + $urandom_range(0, 15);
            wb_push_data = {$urandom, $urandom, $urandom, $urandom};
            mem_wr_ack   = mem_wr_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
`ifdef WB_FORWARD_EN
            lookup_en   = ($urandom_range(0, 1) == 1);
            lookup_addr = 32'h4000 + ($urandom_range(0, 6) << 4) + $urandom_range(0, 15);
`endif
            @(negedge clk);
        end
        wb_push_en = 1'b0;
        mem_wr_ack = 1'b0;
`ifdef WB_FORWARD_EN
        lookup_en = 1'b0;
`endif
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/write_buffer.md
# write_buffer

Buffers dirty cachelines evicted by the data cache and drains them to main memory in FIFO order, so that a miss refill does not wait for the write-back. It sits directly downstream of the cache data RAM, consuming its `write_buffer_en` / `addr_to_write_buffer` / `data_to_write_buffer` outputs, and upstream of the main-memory write port. An optional lookup port lets the miss path read a line that is still pending in the buffer.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `CACHELINE_WIDTH`, 128, line width in bits (4 words).
- `OFFSET_WIDTH`, 4, line-offset bits; these are cleared in stored addresses.
- `DEPTH`, 4, number of entries; must be a power of two and at least 2.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wb_push_en`  in  1  push request from the data RAM, valid for one cycle.
- `wb_push_addr`  in  ADDR_WIDTH  address of the evicted line.
- `wb_push_data`  in  CACHELINE_WIDTH  data of the evicted line.
- `wb_full`  out  1  set when count == DEPTH; registered.
- `wb_empty`  out  1  set when count == 0; registered.
- `wb_overflow`  out  1  sticky flag; set when a push arrives while full.
- `mem_wr_req`  out  1  write request to main memory.
- `mem_wr_addr`  out  ADDR_WIDTH  line address; bits [OFFSET_WIDTH-1:0] are always 0.
- `mem_wr_data`  out  CACHELINE_WIDTH  line data.
- `mem_wr_ack`  in  1  memory has accepted the write, one-cycle pulse.
- `lookup_en`  in  1  forwarding lookup; present only with WB_FORWARD_EN.
- `lookup_addr`  in  ADDR_WIDTH  lookup address; present only with WB_FORWARD_EN.
- `lookup_hit`  out  1  lookup matched a pending entry; present only with WB_FORWARD_EN.
- `lookup_data`  out  CACHELINE_WIDTH  data of the matching entry; present only with WB_FORWARD_EN.

## Operation
- Storage is a circular FIFO: DEPTH entries, each holding {valid, line address, data}.
  - `wr_ptr` and `rd_ptr` are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - `count` is log2(DEPTH)+1 bits wide.
- Push:
  - When `wb_push_en` is high and `wb_full` is low, store the entry at `wr_ptr`, advance `wr_ptr`, and increment `count`.
  - The stored address is `wb_push_addr` with the offset bits zeroed.
- Push while full: the entry is dropped, `wb_overflow` is set and stays set until reset, and the FIFO state is unchanged.
- Drain FSM, IDLE/REQ:
  - IDLE: if `count` != 0, load the head entry into `mem_wr_addr`/`mem_wr_data`, set `mem_wr_req`, and go to REQ.
  - REQ: hold `mem_wr_req`, `mem_wr_addr` and `mem_wr_data` stable until `mem_wr_ack`.
  - On ack: clear the head valid bit, advance `rd_ptr`, decrement `count`, clear `mem_wr_req`, and go to IDLE.
- Simultaneous push and ack in the same cycle: both take effect and `count` is unchanged. A push is still refused if `wb_full` was high that cycle.
- `mem_wr_ack` received in IDLE is ignored.
- Reset mid-operation: all entries are discarded and the FSM returns to IDLE. Losing pending lines is accepted behaviour; the reset is system-wide.

## Timing
- Reset values:
  - `wb_full`=0, `wb_empty`=1, `wb_overflow`=0.
  - `mem_wr_req`=0, `mem_wr_addr`=0, `mem_wr_data`=0.
  - `lookup_hit`=0, `lookup_data`=0; all valid bits 0; both pointers 0; FSM in IDLE.
- A push sampled at edge N:
  - `wb_empty`/`wb_full` reflect it after edge N.
  - `mem_wr_req` rises after edge N+1 when the FIFO was empty and the FSM was in IDLE.
- An ack sampled at edge M drops `mem_wr_req` after edge M. The next request rises no earlier than after edge M+1, giving at least one low cycle between transfers.
- Minimum push-to-memory latency is 2 cycles. Sustained drain is one line per 2 cycles plus memory wait time.

## Configuration
- `WB_FORWARD_EN` defined:
  - The lookup port exists.
  - `lookup_addr[ADDR_WIDTH-1:OFFSET_WIDTH]` is compared against every valid entry.
  - Results are registered one cycle after `lookup_en`: `lookup_hit` is set and `lookup_data` is taken from the youngest matching entry (nearest `wr_ptr`-1).
  - If `lookup_en` is low, or no entry matches, the next cycle gives `lookup_hit`=0 and `lookup_data`=0.
  - An entry popped on the same edge as the lookup does not match.
- `WB_FORWARD_EN` undefined: the lookup ports and compare logic are absent. Only FIFO and drain behaviour remain.

## Test plan
- Reset, then one push of addr 0x0000_1234, data 0xA..A -> `mem_wr_req`=1 two cycles later with `mem_wr_addr`=0x0000_1230. Ack -> `wb_empty`=1 and `mem_wr_req`=0.
- Push 5 lines back-to-back with DEPTH=4 and ack held low -> `wb_full`=1 after the 4th push, the 5th is dropped, `wb_overflow`=1. Drain order is lines 1-4.
- Ack withheld for 10 cycles -> `mem_wr_addr`/`mem_wr_data` stay stable and `mem_wr_req` stays 1 the whole time.
- Buffer full; push and ack on the same edge -> push refused, `count`=3. Push plus ack at `count`=2 -> `count` stays 2. Pointer wrap verified over 12 push/pop pairs.
- `WB_FORWARD_EN`: push 0x100 with data D1, then 0x100 with data D2; lookup 0x10C -> `lookup_hit`=1 and `lookup_data`=D2 next cycle. Lookup 0x200 -> `lookup_hit`=0.
- Assert `rst_n` low while in REQ -> all outputs return to their reset values at once, and a later push drains normally.
